// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: glyph-code messages through a frame-synchronous
// shadow buffer, with a built-in font, per-digit dp/blink and PWM brightness.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS            = 4,
    parameter int unsigned DWELL_CYCLES      = 100_000,
    parameter int unsigned DIM_BITS          = 4,
    parameter int unsigned BLINK_HALF_CYCLES = 50_000_000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    input  logic [DIGITS*5-1:0]   msg_glyphs,
    input  logic [DIGITS-1:0]     msg_dp,
    input  logic [DIGITS-1:0]     msg_blink,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [0:6]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned SLOTS    = 2 ** DIM_BITS;
    localparam int unsigned SLOT_LEN = DWELL_CYCLES / SLOTS;
    localparam int unsigned SW       = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BW       = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

    logic [SW-1:0]         r_slot_cnt;
    logic [DIM_BITS-1:0]   r_slot;
    logic [IW-1:0]         r_idx;
    logic [DIM_BITS-1:0]   r_bright;
    logic [BW-1:0]         r_blink_cnt;
    logic                  r_blink_phase;
    logic [DIGITS*5-1:0]   r_sh_glyphs, r_pd_glyphs;
    logic [DIGITS-1:0]     r_sh_dp, r_pd_dp, r_sh_blink, r_pd_blink;
    logic                  r_pd_valid;
    logic                  r_ready;
    logic [DIGITS-1:0]     r_an;
    logic [0:6]            r_seg;
    logic                  r_dp;
    logic                  r_frame_tick;

    logic                  w_slot_end, w_dwell_start, w_dwell_end, w_boundary;
    logic                  w_accept, w_commit, w_dark;
    logic [4:0]            w_glyph;
    logic                  w_dp_bit, w_blink_bit;
    logic [DIGITS-1:0]     w_an_sel;

    function automatic logic [0:6] font(input logic [4:0] g);
        logic [0:6] s;
        case (g)
            5'h00: s = 7'b0000001;
            5'h01: s = 7'b1001111;
            5'h02: s = 7'b0010010;
            5'h03: s = 7'b0000110;
            5'h04: s = 7'b1001100;
            5'h05: s = 7'b0100100;
            5'h06: s = 7'b0100000;
            5'h07: s = 7'b0001111;
            5'h08: s = 7'b0000000;
            5'h09: s = 7'b0000100;
            5'h0A: s = 7'b0001000;
            5'h0B: s = 7'b1100000;
            5'h0C: s = 7'b0110001;
            5'h0D: s = 7'b1000010;
            5'h0E: s = 7'b0110000;
            5'h0F: s = 7'b0111000;
            5'h11: s = 7'b1111110;
            5'h12: s = 7'b1110001;
            5'h13: s = 7'b0011000;
            5'h14: s = 7'b1000001;
            5'h15: s = 7'b1101010;
            5'h16: s = 7'b1100010;
            5'h17: s = 7'b1111010;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_slot_end    = (r_slot_cnt == SW'(SLOT_LEN - 1));
    assign w_dwell_start = (r_slot_cnt == '0) && (r_slot == '0);
    assign w_dwell_end   = w_slot_end && (r_slot == '1);
    assign w_boundary    = w_dwell_end && (r_idx == '0);
    assign w_accept      = msg_valid && r_ready;
    assign w_commit      = w_boundary && r_pd_valid;

    always_comb begin
        w_glyph     = 5'h10;
        w_dp_bit    = 1'b0;
        w_blink_bit = 1'b0;
        w_an_sel    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_glyph     = r_sh_glyphs[i*5 +: 5];
                w_dp_bit    = r_sh_dp[i];
                w_blink_bit = r_sh_blink[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    // Slot 0 is always lit, so the brightness register only matters once it is loaded
    assign w_dark = (r_slot > r_bright) || (w_blink_bit && r_blink_phase);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt <= '0;
            r_slot     <= '0;
            r_idx      <= IW'(DIGITS - 1);
            r_bright   <= '0;
        end else begin
            if (w_dwell_start) r_bright <= brightness;
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_slot     <= r_slot + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
            if (w_dwell_end) r_idx <= (r_idx == '0) ? IW'(DIGITS - 1) : r_idx - 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_HALF_CYCLES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Accept and commit are exclusive: a pending message always holds r_ready low
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_glyphs <= {DIGITS{5'h10}};
            r_sh_dp     <= '0;
            r_sh_blink  <= '0;
            r_pd_glyphs <= '0;
            r_pd_dp     <= '0;
            r_pd_blink  <= '0;
            r_pd_valid  <= 1'b0;
            r_ready     <= 1'b1;
        end else if (w_accept) begin
            r_pd_glyphs <= msg_glyphs;
            r_pd_dp     <= msg_dp;
            r_pd_blink  <= msg_blink;
            r_pd_valid  <= 1'b1;
            r_ready     <= 1'b0;
        end else if (w_commit) begin
            r_sh_glyphs <= r_pd_glyphs;
            r_sh_dp     <= r_pd_dp;
            r_sh_blink  <= r_pd_blink;
            r_pd_valid  <= 1'b0;
            r_ready     <= 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_an         <= '1;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_dark ? '1 : w_an_sel;
            r_seg        <= w_dark ? 7'b1111111 : font(w_glyph);
            r_dp         <= w_dark ? 1'b1 : ~w_dp_bit;
            r_frame_tick <= w_boundary;
        end
    end

    assign msg_ready  = r_ready;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with a 16-cycle dwell and 4-level dimming.
module tb_seg7_scan_ctrl;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b1;
    logic [19:0] msg_glyphs = '0;
    logic [3:0]  msg_dp     = '0;
    logic [3:0]  msg_blink  = '0;
    logic        msg_valid  = 1'b0;
    logic        msg_ready;
    logic [1:0]  brightness = 2'd3;
    logic [0:6]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int k       = 0;
    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_ctrl #(
        .DIGITS            (4),
        .DWELL_CYCLES      (16),
        .DIM_BITS          (2),
        .BLINK_HALF_CYCLES (256)
    ) u_dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .msg_glyphs (msg_glyphs),
        .msg_dp     (msg_dp),
        .msg_blink  (msg_blink),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @k=%0d: got %h, expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp);
        check({tag, ".an"}, 32'(an), 32'(e_an));
        check({tag, ".seg"}, 32'(seg), 32'(e_seg));
        check({tag, ".dp"}, 32'(dp), 32'(e_dp));
    endtask

    // Advance to sample point k = t, i.e. 1 time unit after the t-th edge since release
    task automatic goto(input int t);
        while (k < t) begin
            @(posedge clk_100MHz);
            #1;
            k++;
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst.ready", 32'(msg_ready), 1);
        check("rst.ft", 32'(frame_tick), 0);
        chk_out("rst", 4'b1111, 7'b1111111, 1'b1);
        repeat (3) @(posedge clk_100MHz);
        #1 reset_n = 1'b1;
        k = 0;

        // Blank scan after reset, digit 3 first
        goto(1);   chk_out("scan3", 4'b0111, 7'b1111111, 1'b1);
        goto(16);  chk_out("scan3e", 4'b0111, 7'b1111111, 1'b1);
        goto(17);  chk_out("scan2", 4'b1011, 7'b1111111, 1'b1);
        goto(33);  chk_out("scan1", 4'b1101, 7'b1111111, 1'b1);
        goto(49);  chk_out("scan0", 4'b1110, 7'b1111111, 1'b1);
        goto(63);  check("ft.pre", 32'(frame_tick), 0);
        goto(64);  check("ft.1", 32'(frame_tick), 1);
        goto(65);  check("ft.post", 32'(frame_tick), 0);
                   check("wrap.an", 32'(an), 32'(4'b0111));
        goto(128); check("ft.2", 32'(frame_tick), 1);

        // Message 1; message 2 offered while busy
        goto(130);
        msg_glyphs = {5'h0C, 5'h14, 5'h13, 5'h03};
        msg_valid  = 1'b1;
        goto(131); check("m1.busy", 32'(msg_ready), 0);
        msg_glyphs = {5'h12, 5'h11, 5'h15, 5'h17};
        goto(191); check("m1.busy_end", 32'(msg_ready), 0);
        goto(192); check("m1.ready", 32'(msg_ready), 1);
                   chk_out("m1.before", 4'b1110, 7'b1111111, 1'b1);
        goto(193); check("m2.acc", 32'(msg_ready), 0);
        msg_valid = 1'b0;
                   chk_out("m1.d3", 4'b0111, 7'b0110001, 1'b1);
        goto(209); chk_out("m1.d2", 4'b1011, 7'b1000001, 1'b1);
        goto(225); chk_out("m1.d1", 4'b1101, 7'b0011000, 1'b1);
        goto(241); chk_out("m1.d0", 4'b1110, 7'b0000110, 1'b1);

        // Minimum brightness from the dwell starting at cycle 256
        goto(250); brightness = 2'd0;
        goto(255); check("m2.busy", 32'(msg_ready), 0);
        goto(256); check("m2.ready", 32'(msg_ready), 1);
                   chk_out("m2.before", 4'b1110, 7'b0000110, 1'b1);
        goto(257); chk_out("dim.s0a", 4'b0111, 7'b1110001, 1'b1);
        goto(260); chk_out("dim.s0b", 4'b0111, 7'b1110001, 1'b1);
        goto(261); chk_out("dim.off", 4'b1111, 7'b1111111, 1'b1);
        goto(272); chk_out("dim.offe", 4'b1111, 7'b1111111, 1'b1);
        goto(273); chk_out("dim.d2", 4'b1011, 7'b1111110, 1'b1);
        goto(277); chk_out("dim.d2off", 4'b1111, 7'b1111111, 1'b1);
        goto(280); brightness = 2'd3;
        goto(289); chk_out("full.d1", 4'b1101, 7'b1101010, 1'b1);

        // Message 3: blink digit 0, dp on digit 1
        goto(290);
        msg_glyphs = {5'h01, 5'h02, 5'h04, 5'h05};
        msg_dp     = 4'b0010;
        msg_blink  = 4'b0001;
        msg_valid  = 1'b1;
        goto(291); check("m3.busy", 32'(msg_ready), 0);
        msg_valid = 1'b0;
        goto(300); chk_out("full.s2", 4'b1101, 7'b1101010, 1'b1);
        goto(319); check("m3.busy_end", 32'(msg_ready), 0);
        goto(320); check("m3.ready", 32'(msg_ready), 1);
        goto(321); chk_out("m3.d3", 4'b0111, 7'b1001111, 1'b1);
        goto(337); chk_out("m3.d2", 4'b1011, 7'b0010010, 1'b1);
        goto(353); chk_out("m3.d1dp", 4'b1101, 7'b1001100, 1'b0);
        goto(369); chk_out("blink.dark", 4'b1111, 7'b1111111, 1'b1);
        goto(384); chk_out("blink.darke", 4'b1111, 7'b1111111, 1'b1);
        goto(561); chk_out("blink.lit", 4'b1110, 7'b0100100, 1'b1);
        goto(769); chk_out("blink.d3", 4'b0111, 7'b1001111, 1'b1);
        goto(817); chk_out("blink.dark2", 4'b1111, 7'b1111111, 1'b1);

        // Message 4 pending, then asynchronous reset mid-dwell
        goto(840);
        msg_glyphs = {4{5'h08}};
        msg_dp     = 4'b1111;
        msg_blink  = 4'b0000;
        msg_valid  = 1'b1;
        goto(841); check("m4.busy", 32'(msg_ready), 0);
        msg_valid = 1'b0;
        goto(850);
        #2 reset_n = 1'b0;
        #1;
        check("arst.ready", 32'(msg_ready), 1);
        check("arst.ft", 32'(frame_tick), 0);
        chk_out("arst", 4'b1111, 7'b1111111, 1'b1);
        repeat (2) @(posedge clk_100MHz);
        #1 reset_n = 1'b1;
        k = 0;

        goto(1);   check("post.ready", 32'(msg_ready), 1);
                   chk_out("post.d3", 4'b0111, 7'b1111111, 1'b1);
        goto(33);  chk_out("post.d1", 4'b1101, 7'b1111111, 1'b1);

        // Message 5 accepted on a boundary cycle commits one frame later
        goto(63);  check("m5.ready", 32'(msg_ready), 1);
        msg_glyphs = {4{5'h00}};
        msg_dp     = 4'b0000;
        msg_valid  = 1'b1;
        goto(64);  check("m5.busy", 32'(msg_ready), 0);
                   check("post.ft", 32'(frame_tick), 1);
        msg_valid = 1'b0;
        goto(65);  chk_out("m5.notyet", 4'b0111, 7'b1111111, 1'b1);
        goto(127); check("m5.busy_end", 32'(msg_ready), 0);
        goto(128); check("m5.commit", 32'(msg_ready), 1);
        goto(129); chk_out("m5.d3", 4'b0111, 7'b0000001, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
